// File: rtl/trg_mon_frame_tx_pkg.sv
// Shared types and constants for the trigger monitor telemetry frame sequencer.
package trg_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_HDR,
    ST_CNT,
    ST_RD,
    ST_LAT,
    ST_DATA,
    ST_SUM
  } state_t;

  localparam logic [15:0] HDR_WORD   = 16'hEB90;
  localparam logic [7:0]  FIRST_ADDR = 8'h02;
  localparam logic [7:0]  LAST_ADDR  = 8'h24;

  // Header + counter + data words + checksum.
  localparam int unsigned FRAME_WORDS = int'(LAST_ADDR) - int'(FIRST_ADDR) + 4;

endpackage

// File: rtl/trg_mon_frame_tx_if.sv
// Telemetry link word stream: valid/ready handshake carrying 16-bit frame words.
interface trg_mon_frame_tx_if;
  logic [15:0] tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;

  modport master (output tx_data_out, output tx_valid_out, input tx_ready_in);
  modport slave  (input tx_data_out, input tx_valid_out, output tx_ready_in);
endinterface

// File: rtl/trg_mon_frame_tx.sv
// Snapshots the monitor bank on request, reads FIRST_ADDR..LAST_ADDR and emits
// header / frame counter / data words / checksum over the telemetry link.
module trg_mon_frame_tx #(
  parameter logic [7:0]  FIRST_ADDR = trg_mon_pkg::FIRST_ADDR,
  parameter logic [7:0]  LAST_ADDR  = trg_mon_pkg::LAST_ADDR,
  parameter logic [15:0] HDR_WORD   = trg_mon_pkg::HDR_WORD
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      tel_req_in,
  output logic                      store_en_out,
  output logic                      rd_out,
  output logic [7:0]                rd_addr_out,
  input  logic [15:0]               mon_data_in,
  trg_mon_frame_tx_if.master        tx,
  output logic                      busy_out,
  output logic [15:0]               frame_cnt_out,
  output logic [7:0]                req_drop_cnt_out
);
  import trg_mon_pkg::*;

  state_t      state_q, state_d;
  logic [15:0] frame_cnt;
  logic [15:0] csum_q;
  logic [15:0] buf_q;
  logic [7:0]  addr_q;
  logic [7:0]  drop_q;
  logic        ready;

  assign ready            = tx.tx_ready_in;
  assign rd_addr_out      = addr_q;
  assign frame_cnt_out    = frame_cnt;
  assign req_drop_cnt_out = drop_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (tel_req_in) state_d = ST_SNAP;
      ST_SNAP: state_d = ST_HDR;
      ST_HDR:  if (ready) state_d = ST_CNT;
      ST_CNT:  if (ready) state_d = ST_RD;
      ST_RD:   state_d = ST_LAT;
      ST_LAT:  state_d = ST_DATA;
      ST_DATA: if (ready) state_d = (addr_q == LAST_ADDR) ? ST_SUM : ST_RD;
      ST_SUM:  if (ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Link outputs depend only on state and registers, never on tx_ready_in.
  always_comb begin
    store_en_out    = 1'b0;
    rd_out          = 1'b0;
    tx.tx_valid_out = 1'b0;
    tx.tx_data_out  = '0;
    busy_out        = (state_q != ST_IDLE);
    unique case (state_q)
      ST_SNAP: store_en_out = 1'b1;
      ST_RD:   rd_out       = 1'b1;
      ST_HDR: begin
        tx.tx_valid_out = 1'b1;
        tx.tx_data_out  = HDR_WORD;
      end
      ST_CNT: begin
        tx.tx_valid_out = 1'b1;
        tx.tx_data_out  = frame_cnt;
      end
      ST_DATA: begin
        tx.tx_valid_out = 1'b1;
        tx.tx_data_out  = buf_q;
      end
      ST_SUM: begin
        tx.tx_valid_out = 1'b1;
        tx.tx_data_out  = csum_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_cnt <= '0;
      csum_q    <= '0;
      buf_q     <= '0;
      addr_q    <= FIRST_ADDR;
      drop_q    <= '0;
    end else begin
      if (tel_req_in && state_q != ST_IDLE && drop_q != '1)
        drop_q <= drop_q + 8'd1;
      unique case (state_q)
        ST_SNAP: csum_q <= '0;
        ST_CNT: if (ready) begin
          csum_q <= csum_q + frame_cnt;
          addr_q <= FIRST_ADDR;
        end
        ST_LAT:  buf_q <= mon_data_in;
        ST_DATA: if (ready) begin
          csum_q <= csum_q + buf_q;
          if (addr_q != LAST_ADDR) addr_q <= addr_q + 8'd1;
        end
        ST_SUM:  if (ready) frame_cnt <= frame_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trg_mon_frame_tx.sv
// Randomized scoreboard bench for trg_mon_frame_tx with a behavioural bank model.
module tb_trg_mon_frame_tx;
  localparam logic [7:0]  FA  = 8'h02;
  localparam logic [7:0]  LA  = 8'h24;
  localparam logic [15:0] HDR = 16'hEB90;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        tel_req_in = 1'b0;
  logic        store_en_out, rd_out, busy_out;
  logic [7:0]  rd_addr_out, req_drop_cnt_out;
  logic [15:0] mon_data_in = '0;
  logic [15:0] frame_cnt_out;

  trg_mon_frame_tx_if tx_if ();

  trg_mon_frame_tx #(.FIRST_ADDR(FA), .LAST_ADDR(LA), .HDR_WORD(HDR)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .tel_req_in       (tel_req_in),
    .store_en_out     (store_en_out),
    .rd_out           (rd_out),
    .rd_addr_out      (rd_addr_out),
    .mon_data_in      (mon_data_in),
    .tx               (tx_if),
    .busy_out         (busy_out),
    .frame_cnt_out    (frame_cnt_out),
    .req_drop_cnt_out (req_drop_cnt_out)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [15:0] exp_q[$];
  int          ready_pct = 100;
  logic [15:0] m_cnt = '0;
  int          m_drop = 0;

  always #10 clk_in = ~clk_in;

  // Monitor bank: returns {A0, addr} the cycle after a read strobe.
  always @(posedge clk_in) if (rd_out) mon_data_in <= {8'hA0, rd_addr_out};

  always @(posedge clk_in) begin
    #2;
    tx_if.tx_ready_in = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;

  always @(negedge clk_in) begin
    if (rst_in && tx_if.tx_valid_out) begin
      if (stall_prev) check("hold_data", 32'(tx_if.tx_data_out), 32'(stall_data));
      if (tx_if.tx_ready_in) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h, expected no word", tx_if.tx_data_out);
        end else begin
          check("word", 32'(tx_if.tx_data_out), 32'(exp_q.pop_front()));
        end
        stall_prev <= 1'b0;
      end else begin
        stall_prev <= 1'b1;
        stall_data <= tx_if.tx_data_out;
      end
    end else begin
      if (rst_in) begin
        check("idle_data_zero", 32'(tx_if.tx_data_out), 32'h0);
        if (stall_prev) check("valid_dropped", 32'(tx_if.tx_valid_out), 32'h1);
      end
      stall_prev <= 1'b0;
    end
  end

  task automatic push_frame();
    logic [15:0] s;
    logic [15:0] w;
    exp_q.push_back(HDR);
    exp_q.push_back(m_cnt);
    s = m_cnt;
    for (int a = int'(FA); a <= int'(LA); a++) begin
      w = {8'hA0, 8'(a)};
      exp_q.push_back(w);
      s = s + w;
    end
    exp_q.push_back(s);
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic run_frame(input bit flood, input bit pulses, input bit timing);
    int k, stores, rds, overlap, first_store;
    bit done;
    k = 0; stores = 0; rds = 0; overlap = 0; first_store = 0; done = 0;
    @(negedge clk_in);
    tel_req_in = 1'b1;
    push_frame();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_in);
      tel_req_in = 1'b0;
      if (!busy_out) begin
        done = 1;
        break;
      end
      k++;
      if (store_en_out) begin
        stores++;
        if (first_store == 0) first_store = k;
      end
      if (rd_out) rds++;
      if (store_en_out && rd_out) overlap++;
      if (flood || (pulses && (k == 10 || k == 50 || k == 80 || k == 109))) begin
        tel_req_in = 1'b1;
        m_drop++;
      end
    end
    tel_req_in = 1'b0;
    check("frame_timeout", 32'(done), 32'h1);
    if (timing) begin
      check("busy_cycles", 32'(k), 32'd109);
      check("store_first", 32'(first_store), 32'd1);
    end
    check("store_pulses", 32'(stores), 32'd1);
    check("rd_pulses", 32'(rds), 32'd35);
    check("strobe_overlap", 32'(overlap), 32'd0);
    repeat (3) @(negedge clk_in);
    check("words_outstanding", 32'(exp_q.size()), 32'd0);
    check("busy_after", 32'(busy_out), 32'd0);
    check("frame_cnt", 32'(frame_cnt_out), 32'(m_cnt));
    check("drop_cnt", 32'(req_drop_cnt_out), 32'((m_drop > 255) ? 255 : m_drop));
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_store", 32'(store_en_out), 32'h0);
    check("rst_rd", 32'(rd_out), 32'h0);
    check("rst_addr", 32'(rd_addr_out), 32'(FA));
    check("rst_valid", 32'(tx_if.tx_valid_out), 32'h0);
    check("rst_data", 32'(tx_if.tx_data_out), 32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_frame_cnt", 32'(frame_cnt_out), 32'h0);
    check("rst_drop", 32'(req_drop_cnt_out), 32'h0);
    rst_in = 1'b1;

    run_frame(0, 0, 1);
    run_frame(0, 0, 1);

    ready_pct = 30;
    run_frame(0, 0, 0);
    ready_pct = 100;

    run_frame(0, 1, 1);
    repeat (3) run_frame(1, 0, 1);

    // Abort a frame while the word from address 0x10 is on the link.
    @(negedge clk_in);
    tel_req_in = 1'b1;
    push_frame();
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk_in);
        tel_req_in = 1'b0;
        if (busy_out && tx_if.tx_valid_out && rd_addr_out == 8'h10) begin
          hit = 1;
          break;
        end
      end
      check("reach_addr10", 32'(hit), 32'h1);
    end
    rst_in = 1'b0;
    #1;
    check("abort_store", 32'(store_en_out), 32'h0);
    check("abort_rd", 32'(rd_out), 32'h0);
    check("abort_addr", 32'(rd_addr_out), 32'(FA));
    check("abort_valid", 32'(tx_if.tx_valid_out), 32'h0);
    check("abort_data", 32'(tx_if.tx_data_out), 32'h0);
    check("abort_busy", 32'(busy_out), 32'h0);
    check("abort_frame_cnt", 32'(frame_cnt_out), 32'h0);
    check("abort_drop", 32'(req_drop_cnt_out), 32'h0);
    exp_q.delete();
    m_cnt = '0;
    m_drop = 0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    run_frame(0, 0, 1);

    @(negedge clk_in);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk_in);
    release dut.frame_cnt;
    m_cnt = 16'hFFFF;
    check("forced_cnt", 32'(frame_cnt_out), 32'h0000FFFF);
    run_frame(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
